// File: rtl/siso.sv
// Serial-in serial-out shift register: a fixed DATA_WIDTH-cycle delay line for a 1-bit stream.
// Every stage is its own flop with an asynchronous active-low clear.
module siso #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic serial_out
);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("siso: DATA_WIDTH must be >= 1 (got %0d)", DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] sr;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_stage
    logic d;
    logic q;

    // Stage 0 samples the serial input; every later stage takes its predecessor.
    if (i == 0) begin : g_head
      assign d = serial_in;
    end else begin : g_tail
      assign d = sr[i-1];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= 1'b0;
      end else begin
        q <= d;
      end
    end

    assign sr[i] = q;
  end

  assign serial_out = sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_siso.sv
// Bench for siso: four instances (widths 32, 4, 8, 1) checked against fixed vectors,
// hand-written reset sequences and a history-based model of the delay line.
module tb_siso;

  logic clk;
  logic rst32, rst4, rst8, rst1;
  logic si32, si4, si8, si1;
  logic so32, so4, so8, so1;

  int n_checks = 0;
  int n_fail   = 0;

  // Every bit sampled since the last reset; the output is the bit sampled W edges back.
  logic [0:0] exp_q32[$];
  logic [0:0] exp_q4[$];
  logic [0:0] exp_q8[$];
  logic [0:0] exp_q1[$];

  typedef struct {
    logic in_bit;
    logic exp_out;
  } vec_t;

  vec_t vec4[12];

  siso #(.DATA_WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .serial_in(si32), .serial_out(so32));
  siso #(.DATA_WIDTH(4))  dut4  (.clk(clk), .reset(rst4),  .serial_in(si4),  .serial_out(so4));
  siso #(.DATA_WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .serial_in(si8),  .serial_out(so8));
  siso #(.DATA_WIDTH(1))  dut1  (.clk(clk), .reset(rst1),  .serial_in(si1),  .serial_out(so1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  always @(posedge clk) begin
    if (!rst32) exp_q32.delete(); else exp_q32.push_back(si32);
    if (!rst4)  exp_q4.delete();  else exp_q4.push_back(si4);
    if (!rst8)  exp_q8.delete();  else exp_q8.push_back(si8);
    if (!rst1)  exp_q1.delete();  else exp_q1.push_back(si1);
  end

  function automatic logic model_out(input logic [0:0] h[$], input int w, input logic rst_n);
    if (!rst_n) return 1'b0;
    if (h.size() < w) return 1'b0;
    return h[h.size() - w];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models(input string tag);
    check({tag, "_w32"}, so32, model_out(exp_q32, 32, rst32));
    check({tag, "_w4"},  so4,  model_out(exp_q4,  4,  rst4));
    check({tag, "_w8"},  so8,  model_out(exp_q8,  8,  rst8));
    check({tag, "_w1"},  so1,  model_out(exp_q1,  1,  rst1));
  endtask

  initial begin
    logic prev;

    vec4[0]  = '{1'b1, 1'b0};
    vec4[1]  = '{1'b0, 1'b0};
    vec4[2]  = '{1'b1, 1'b0};
    vec4[3]  = '{1'b1, 1'b1};
    vec4[4]  = '{1'b0, 1'b0};
    vec4[5]  = '{1'b0, 1'b1};
    vec4[6]  = '{1'b1, 1'b1};
    vec4[7]  = '{1'b0, 1'b0};
    vec4[8]  = '{1'b0, 1'b0};
    vec4[9]  = '{1'b0, 1'b1};
    vec4[10] = '{1'b0, 1'b0};
    vec4[11] = '{1'b0, 1'b0};

    rst32 = 1'b0; rst4 = 1'b0; rst8 = 1'b0; rst1 = 1'b0;
    si32 = 1'b0; si4 = 1'b0; si8 = 1'b0; si1 = 1'b0;
    @(negedge clk);

    // Test 1: reset held with random input
    for (int c = 0; c < 5; c++) begin
      si32 = 1'($urandom); si4 = 1'($urandom); si8 = 1'($urandom); si1 = 1'($urandom);
      step();
      check("rst_out_w32", so32, 1'b0);
      check("rst_out_w4",  so4,  1'b0);
      check("rst_out_w8",  so8,  1'b0);
      check("rst_out_w1",  so1,  1'b0);
      check("rst_sr_w32",  |dut32.sr, 1'b0);
    end

    // Test 2: single 1 through the 32-deep line
    rst32 = 1'b1;
    si32 = 1'b1;
    step();
    check("pulse_e1", so32, 1'b0);
    si32 = 1'b0;
    for (int e = 2; e <= 40; e++) begin
      step();
      check("pulse", so32, (e == 32) ? 1'b1 : 1'b0);
      check_models("pulse_model");
    end

    // Test 3: 32 random bits then zeros
    rst32 = 1'b0;
    step();
    rst32 = 1'b1;
    for (int e = 1; e <= 72; e++) begin
      si32 = (e <= 32) ? 1'($urandom) : 1'b0;
      step();
      check("rand32", so32, model_out(exp_q32, 32, rst32));
    end

    // Test 4: fixed stream through the 4-deep line
    rst4 = 1'b0;
    step();
    rst4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      si4 = vec4[i].in_bit;
      step();
      check("vec_w4", so4, vec4[i].exp_out);
    end

    // Test 5: fill the 8-deep line with ones, then clear it between edges
    rst8 = 1'b0;
    step();
    rst8 = 1'b1;
    si8 = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    check("fill_w8", so8, 1'b1);
    #2;
    rst8 = 1'b0;
    #1;
    check("async_clr_w8", so8, 1'b0);
    si8 = 1'b0;
    step();
    check("held_clr_w8", so8, 1'b0);
    #2;
    rst8 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("post_clr_w8", so8, 1'b0);
    end

    // Test 6: toggling input through the 1-deep line
    rst1 = 1'b0;
    step();
    rst1 = 1'b1;
    si1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      si1 = ~si1;
      prev = si1;
      step();
      check("toggle_w1", so1, prev);
    end

    // Random streams with occasional resets on all widths
    rst32 = 1'b1; rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      si32 = 1'($urandom); si4 = 1'($urandom); si8 = 1'($urandom); si1 = 1'($urandom);
      rst32 = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      rst4  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      rst8  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      rst1  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      step();
      check_models("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
